// File: rtl/bk_video_pkg.sv
// Shared types for the screen cache path: the queued write entry and the drain FSM states.
package bk_video_pkg;

    // wb_adr[15:14] value selecting the CPU screen window 040000-077777
    localparam logic [1:0] SCREEN_WIN_BASE = 2'b01;

    typedef struct packed {
        logic        scr;
        logic [13:0] addr;
        logic [15:0] data;
        logic [1:0]  sel;
    } cache_entry_t;

    localparam int CACHE_ENTRY_W = $bits(cache_entry_t);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP
    } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head. A push into a full FIFO is accepted
// only when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_cache_writer.sv
// Snoops CPU Wishbone writes into the two screen pages, queues them, and replays them
// as spaced one-cycle cache_we strobes toward the video screen cache.
module vram_cache_writer
    import bk_video_pkg::*;
#(
    parameter logic [2:0] SCR0_PAGE  = 3'd1,
    parameter logic [2:0] SCR1_PAGE  = 3'd7,
    parameter int         FIFO_DEPTH = 4,
    parameter int         MIN_GAP    = 1
) (
    input  logic        wb_clk,
    input  logic        sys_init_n,
    input  logic [15:0] wb_adr,
    input  logic [15:0] wb_dat_i,
    input  logic [1:0]  wb_sel,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic        wb_ack,
    input  logic [2:0]  win_page,
    output logic [14:0] cache_addr,
    output logic [15:0] cache_data,
    output logic [1:0]  cache_wtbt,
    output logic        cache_we,
    output logic        ovf
);
    localparam int         CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] GAP_LOAD = (MIN_GAP > 0) ? 3'(MIN_GAP - 1) : 3'd0;

    logic           armed;
    logic           page_hit;
    logic           hit;
    logic           fifo_full;
    logic           fifo_empty;
    logic           launch;
    logic [2:0]     gap_cnt;
    logic [2:0]     gap_next;
    logic [CNT_W-1:0] unused_fifo_count;
    logic           unused_adr0;
    cache_entry_t   push_entry;
    cache_entry_t   head_entry;
    drain_state_t   state;
    drain_state_t   next_state;

    assign unused_adr0 = wb_adr[0];
    assign page_hit    = (win_page == SCR0_PAGE) || (win_page == SCR1_PAGE);
    assign hit         = wb_cyc & wb_stb & wb_we & wb_ack & armed &
                         (wb_adr[15:14] == SCREEN_WIN_BASE) & page_hit & (|wb_sel);

    // Screen 1 wins when both parameters name the same page.
    assign push_entry = '{scr:  (win_page == SCR1_PAGE),
                          addr: {wb_adr[13:1], 1'b0},
                          data: wb_dat_i,
                          sel:  wb_sel};

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CACHE_ENTRY_W)
    ) u_fifo (
        .clk   (wb_clk),
        .rst_n (sys_init_n),
        .push  (hit),
        .din   (push_entry),
        .pop   (launch),
        .dout  (head_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_fifo_count)
    );

    // One capture per bus cycle: re-arm only once the strobe drops.
    always_ff @(posedge wb_clk or negedge sys_init_n) begin
        if (!sys_init_n) begin
            armed <= 1'b1;
            ovf   <= 1'b0;
        end else begin
            if (!wb_stb)  armed <= 1'b1;
            else if (hit) armed <= 1'b0;
            if (hit && fifo_full && !launch) ovf <= 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        next_state = state;
        gap_next   = gap_cnt;
        launch     = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) launch = 1'b1;
            end
            STROBE: begin
                if (MIN_GAP > 0) begin
                    next_state = GAP;
                    gap_next   = GAP_LOAD;
                end else if (!fifo_empty) begin
                    launch = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt != 3'd0)   gap_next   = gap_cnt - 3'd1;
                else if (!fifo_empty)  launch     = 1'b1;
                else                   next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (launch) next_state = STROBE;
    end

    always_ff @(posedge wb_clk or negedge sys_init_n) begin
        if (!sys_init_n) begin
            state      <= IDLE;
            gap_cnt    <= 3'd0;
            cache_we   <= 1'b0;
            cache_addr <= '0;
            cache_data <= '0;
            cache_wtbt <= '0;
        end else begin
            state    <= next_state;
            gap_cnt  <= gap_next;
            cache_we <= launch;
            if (launch) begin
                cache_addr <= {head_entry.scr, head_entry.addr};
                cache_data <= head_entry.data;
                cache_wtbt <= head_entry.sel;
            end
        end
    end

endmodule

// File: tb/tb_vram_cache_writer.sv
// Directed bench: three instances (default, MIN_GAP=2, DEPTH=4/MIN_GAP=7) share the snooped bus.
module tb_vram_cache_writer;

    typedef struct {
        int          cyc;
        logic [14:0] addr;
        logic [15:0] data;
        logic [1:0]  wtbt;
    } strobe_t;

    logic        wb_clk = 1'b0;
    logic        sys_init_n;
    logic [15:0] wb_adr;
    logic [15:0] wb_dat_i;
    logic [1:0]  wb_sel;
    logic        wb_cyc, wb_stb, wb_we, wb_ack;
    logic [2:0]  win_page;

    logic [14:0] addr1, addr2, addr7;
    logic [15:0] data1, data2, data7;
    logic [1:0]  wtbt1, wtbt2, wtbt7;
    logic        we1, we2, we7;
    logic        ovf1, ovf2, ovf7;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc_n        = 0;

    strobe_t q1[$];
    strobe_t q2[$];
    strobe_t q7[$];

    always #5 wb_clk = ~wb_clk;
    always @(posedge wb_clk) cyc_n <= cyc_n + 1;

    vram_cache_writer u_g1 (
        .wb_clk(wb_clk), .sys_init_n(sys_init_n), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
        .wb_sel(wb_sel), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack),
        .win_page(win_page), .cache_addr(addr1), .cache_data(data1), .cache_wtbt(wtbt1),
        .cache_we(we1), .ovf(ovf1));

    vram_cache_writer #(.MIN_GAP(2)) u_g2 (
        .wb_clk(wb_clk), .sys_init_n(sys_init_n), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
        .wb_sel(wb_sel), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack),
        .win_page(win_page), .cache_addr(addr2), .cache_data(data2), .cache_wtbt(wtbt2),
        .cache_we(we2), .ovf(ovf2));

    vram_cache_writer #(.FIFO_DEPTH(4), .MIN_GAP(7)) u_g7 (
        .wb_clk(wb_clk), .sys_init_n(sys_init_n), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
        .wb_sel(wb_sel), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack),
        .win_page(win_page), .cache_addr(addr7), .cache_data(data7), .cache_wtbt(wtbt7),
        .cache_we(we7), .ovf(ovf7));

    // Strobe monitors sample mid-cycle, away from the rising edge.
    always @(negedge wb_clk) begin
        if (we1) q1.push_back('{cyc_n, addr1, data1, wtbt1});
        if (we2) q2.push_back('{cyc_n, addr2, data2, wtbt2});
        if (we7) q7.push_back('{cyc_n, addr7, data7, wtbt7});
    end

    task automatic clear_queues();
        q1.delete();
        q2.delete();
        q7.delete();
    endtask

    task automatic bus_idle();
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_ack = 1'b0;
        wb_adr = '0; wb_dat_i = '0; wb_sel = '0; win_page = 3'd0;
    endtask

    task automatic do_reset();
        @(negedge wb_clk);
        sys_init_n = 1'b0;
        bus_idle();
        repeat (2) @(negedge wb_clk);
        sys_init_n = 1'b1;
        clear_queues();
        @(negedge wb_clk);
    endtask

    // One bus cycle with ack held ack_clks edges; the first sampling edge is cycle drive_cyc+1.
    task automatic bus_cycle(input logic [15:0] adr, input logic [15:0] dat, input logic [1:0] sel,
                             input logic [2:0] page, input logic we, input int ack_clks,
                             output int drive_cyc);
        @(negedge wb_clk);
        drive_cyc = cyc_n;
        wb_adr = adr; wb_dat_i = dat; wb_sel = sel; win_page = page;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_ack = 1'b1;
        repeat (ack_clks) @(negedge wb_clk);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_ack = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (we1 !== 1'b0) begin tests_failed++; $display("FAIL reset_we: got %b expected 0", we1); end
        tests_run++; if (addr1 !== 15'h0) begin tests_failed++; $display("FAIL reset_addr: got %h expected 0000", addr1); end
        tests_run++; if (data1 !== 16'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0000", data1); end
        tests_run++; if (wtbt1 !== 2'b00) begin tests_failed++; $display("FAIL reset_wtbt: got %b expected 00", wtbt1); end
        tests_run++; if (ovf7 !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %b expected 0", ovf7); end
    endtask

    task automatic test_word_write();
        int dc;
        do_reset();
        // octal 040100 = 16'h4040 -> screen 0, byte offset 14'h0040
        bus_cycle(16'o040100, 16'o123456, 2'b11, 3'd1, 1'b1, 1, dc);
        repeat (6) @(negedge wb_clk);
        tests_run++; if (q1.size() != 1) begin tests_failed++; $display("FAIL word_count: got %0d expected 1", q1.size()); end
        if (q1.size() >= 1) begin
            tests_run++; if (q1[0].addr !== 15'h0040) begin tests_failed++; $display("FAIL word_addr: got %h expected 0040", q1[0].addr); end
            tests_run++; if (q1[0].data !== 16'o123456) begin tests_failed++; $display("FAIL word_data: got %o expected 123456", q1[0].data); end
            tests_run++; if (q1[0].wtbt !== 2'b11) begin tests_failed++; $display("FAIL word_wtbt: got %b expected 11", q1[0].wtbt); end
            // cache_we rises on the edge after the ack edge, so the cache samples it two edges on
            tests_run++; if (q1[0].cyc != dc + 2) begin tests_failed++; $display("FAIL word_latency: got cycle %0d expected %0d", q1[0].cyc, dc + 2); end
        end
        tests_run++; if (addr1 !== 15'h0040) begin tests_failed++; $display("FAIL word_hold: got %h expected 0040", addr1); end
    endtask

    task automatic test_byte_write();
        int dc;
        do_reset();
        bus_cycle(16'o077777, 16'hA5C3, 2'b10, 3'd7, 1'b1, 1, dc);
        repeat (6) @(negedge wb_clk);
        tests_run++; if (q1.size() != 1) begin tests_failed++; $display("FAIL byte_count: got %0d expected 1", q1.size()); end
        if (q1.size() >= 1) begin
            tests_run++; if (q1[0].addr !== 15'h7FFE) begin tests_failed++; $display("FAIL byte_addr: got %h expected 7ffe", q1[0].addr); end
            tests_run++; if (q1[0].wtbt !== 2'b10) begin tests_failed++; $display("FAIL byte_wtbt: got %b expected 10", q1[0].wtbt); end
            tests_run++; if (q1[0].data !== 16'hA5C3) begin tests_failed++; $display("FAIL byte_data: got %h expected a5c3", q1[0].data); end
        end
        clear_queues();
        bus_cycle(16'o077777, 16'h1111, 2'b10, 3'd3, 1'b1, 1, dc);
        repeat (6) @(negedge wb_clk);
        tests_run++; if (q1.size() != 0) begin tests_failed++; $display("FAIL other_page: got %0d strobes expected 0", q1.size()); end
    endtask

    task automatic test_non_hits();
        int dc;
        do_reset();
        bus_cycle(16'o040200, 16'h2222, 2'b11, 3'd1, 1'b1, 3, dc);
        repeat (6) @(negedge wb_clk);
        tests_run++; if (q1.size() != 1) begin tests_failed++; $display("FAIL ack_held: got %0d strobes expected 1", q1.size()); end
        clear_queues();
        bus_cycle(16'o040200, 16'h3333, 2'b11, 3'd1, 1'b0, 1, dc);
        repeat (6) @(negedge wb_clk);
        tests_run++; if (q1.size() != 0) begin tests_failed++; $display("FAIL read_cycle: got %0d strobes expected 0", q1.size()); end
        bus_cycle(16'o040200, 16'h4444, 2'b00, 3'd1, 1'b1, 1, dc);
        repeat (6) @(negedge wb_clk);
        tests_run++; if (q1.size() != 0) begin tests_failed++; $display("FAIL sel_zero: got %0d strobes expected 0", q1.size()); end
        bus_cycle(16'o100200, 16'h5555, 2'b11, 3'd1, 1'b1, 1, dc);
        bus_cycle(16'o020200, 16'h6666, 2'b11, 3'd7, 1'b1, 1, dc);
        repeat (6) @(negedge wb_clk);
        tests_run++; if (q1.size() != 0) begin tests_failed++; $display("FAIL outside_window: got %0d strobes expected 0", q1.size()); end
        tests_run++; if (data1 !== 16'h2222) begin tests_failed++; $display("FAIL non_hit_hold: got %h expected 2222", data1); end
    endtask

    task automatic test_back_to_back_gap2();
        int dc;
        do_reset();
        // last two hit the same word: the later data must be the last strobed
        for (int i = 0; i < 4; i++)
            bus_cycle((i < 3) ? 16'(16'o040000 + 2 * i) : 16'o040004, 16'(16'h2000 + i), 2'b11, 3'd1, 1'b1, 1, dc);
        repeat (20) @(negedge wb_clk);
        tests_run++; if (q2.size() != 4) begin tests_failed++; $display("FAIL gap2_count: got %0d expected 4", q2.size()); end
        for (int i = 0; i < 4; i++) begin
            if (q2.size() > i) begin
                tests_run++;
                if (q2[i].data !== 16'(16'h2000 + i)) begin
                    tests_failed++; $display("FAIL gap2_order[%0d]: got %h expected %h", i, q2[i].data, 16'(16'h2000 + i));
                end
                if (i > 0) begin
                    tests_run++;
                    if (q2[i].cyc - q2[i-1].cyc != 3) begin
                        tests_failed++; $display("FAIL gap2_spacing[%0d]: got %0d expected 3", i, q2[i].cyc - q2[i-1].cyc);
                    end
                end
            end
        end
        tests_run++; if (ovf2 !== 1'b0) begin tests_failed++; $display("FAIL gap2_ovf: got %b expected 0", ovf2); end
    endtask

    // Pops every 8 clocks vs. a push every 2: entries 0..5 fit, entry 6 meets a full FIFO.
    task automatic test_overflow();
        int dc;
        do_reset();
        for (int i = 0; i < 7; i++)
            bus_cycle(16'(16'o040000 + 2 * i), 16'(16'h3000 + i), 2'b01, 3'd7, 1'b1, 1, dc);
        repeat (80) @(negedge wb_clk);
        tests_run++; if (q7.size() != 6) begin tests_failed++; $display("FAIL ovf_count: got %0d expected 6", q7.size()); end
        for (int i = 0; i < 6; i++) begin
            if (q7.size() > i) begin
                tests_run++;
                if (q7[i].data !== 16'(16'h3000 + i)) begin
                    tests_failed++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, q7[i].data, 16'(16'h3000 + i));
                end
            end
        end
        tests_run++; if (ovf7 !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag: got %b expected 1", ovf7); end
        tests_run++; if (ovf2 !== 1'b0) begin tests_failed++; $display("FAIL ovf_gap2_clear: got %b expected 0", ovf2); end
    endtask

    task automatic test_reset_mid_drain();
        int  dc;
        bit  seen;
        do_reset();
        for (int i = 0; i < 5; i++)
            bus_cycle(16'(16'o040100 + 2 * i), 16'(16'h4000 + i), 2'b11, 3'd1, 1'b1, 1, dc);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge wb_clk);
            if (we7) begin seen = 1'b1; break; end
        end
        tests_run++; if (!seen) begin tests_failed++; $display("FAIL drain_timeout: got no strobe expected one within 20 cycles"); end
        #1 sys_init_n = 1'b0;
        #1;
        tests_run++; if (we7 !== 1'b0) begin tests_failed++; $display("FAIL async_reset_we: got %b expected 0", we7); end
        tests_run++; if (addr7 !== 15'h0) begin tests_failed++; $display("FAIL async_reset_addr: got %h expected 0000", addr7); end
        clear_queues();
        repeat (2) @(negedge wb_clk);
        sys_init_n = 1'b1;
        repeat (40) @(negedge wb_clk);
        tests_run++; if (q7.size() != 0) begin tests_failed++; $display("FAIL after_reset: got %0d strobes expected 0", q7.size()); end
    endtask

    initial begin
        sys_init_n = 1'b0;
        bus_idle();
        test_reset();
        test_word_write();
        test_byte_write();
        test_non_hits();
        test_back_to_back_gap2();
        test_overflow();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
